msg_schedule: RTL and testbench
===============================

MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 SHALL have CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have RESET_N, input, 1, synchronous active-low reset sampled on the CLK rising edge.
REQ-003 SHALL have WORD_VALID, input, 1, which strobes WORD_IN into the 16-word window during LOAD.
REQ-004 SHALL have WORD_IN, input, 32, a message word, most-significant word of the block first.
REQ-005 SHALL have ADVANCE, input, 1, asserted by the compression stage to consume the current W and step the round.
REQ-006 SHALL have W_OUT, output, 32, the schedule word W[t] for the current round.
REQ-007 SHALL have T_IDX, output, 6, the current round index t.
REQ-008 SHALL have WORD_CNT, output, 5, the number of words loaded in the current block (0..16).
REQ-009 SHALL have BLOCK_READY, output, 1, high while in RUN (W_OUT valid).
REQ-010 SHALL have SCHED_DONE, output, 1, a one-cycle pulse after W[63] is consumed.

Function
REQ-011 SHALL implement states LOAD, RUN and DONE.
REQ-012 In LOAD, each WORD_VALID cycle SHALL write WORD_IN to window[WORD_CNT] and increment WORD_CNT.
REQ-013 The 16th accepted word SHALL move to RUN next cycle with T_IDX=0 and W_OUT=window[0].
REQ-014 In RUN, ADVANCE SHALL shift the window down one slot, so w[0] is dropped and w[15] becomes new.
REQ-015 new SHALL equal (sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0]) mod 2^32.
REQ-016 sigma0 SHALL equal ROTR7 ^ ROTR18 ^ SHR3, and sigma1 SHALL equal ROTR17 ^ ROTR19 ^ SHR10.
REQ-017 Each ADVANCE in RUN SHALL increment T_IDX by 1; W_OUT SHALL always be window[0] (zero latency from register).
REQ-018 ADVANCE with T_IDX=63 SHALL go to DONE; T_IDX SHALL wrap to 0 and no schedule word SHALL be computed.
REQ-019 DONE SHALL last exactly one cycle with SCHED_DONE=1, then return to LOAD with WORD_CNT=0.
REQ-020 WORD_VALID outside LOAD SHALL be ignored; it SHALL NOT be buffered.
REQ-021 ADVANCE outside RUN SHALL be ignored.
REQ-022 With no ADVANCE in RUN, all state SHALL hold indefinitely.
REQ-023 WORD_VALID and ADVANCE together SHALL have only the effect the current state permits.
REQ-024 BLOCK_READY SHALL be 0 in LOAD and DONE.

Reset
REQ-025 RESET_N=0 at a clock edge SHALL force LOAD, WORD_CNT=0, T_IDX=0, SCHED_DONE=0, BLOCK_READY=0, window=0, and W_OUT=0.
REQ-026 Reset SHALL take priority over every input, including a mid-RUN reset, and SHALL discard any partial block.

Configuration
REQ-027 With macro MSG_SCHEDULE_ABORT_EN defined, an ABORT input, 1 bit, SHALL exist.
REQ-028 ABORT=1 SHALL send any state to LOAD next cycle with WORD_CNT=0 and T_IDX=0, without a SCHED_DONE pulse; it SHALL be lower priority than reset.
REQ-029 Without MSG_SCHEDULE_ABORT_EN, the ABORT port and its logic SHALL be absent; behaviour SHALL otherwise be identical.

Structure
REQ-030 Shared package sha256_pkg SHALL hold the state enum, WORDS_PER_BLOCK=16, ROUNDS=64 and word typedef word_t (32-bit).
REQ-031 The sigma0/sigma1 logic SHALL be a combinational sub-module sha256_sigma with a select input, instantiated twice.

Verification
REQ-032 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) loaded -> BLOCK_READY=1, W_OUT=0x61626380, T_IDX=0.
REQ-033 Same block, 16 ADVANCEs -> W16=0x61626380; 17th -> W17=0x000F0000; at T_IDX=63 -> W_OUT=0x12B1EDEB.
REQ-034 64th ADVANCE -> SCHED_DONE high exactly one cycle, then LOAD with WORD_CNT=0; a second block loads correctly.
REQ-035 RESET_N=0 at T_IDX=30 -> all outputs zero next cycle; WORD_VALID during RUN and ADVANCE during LOAD -> no state change.
REQ-036 8 words loaded, WORD_VALID idle 20 cycles, 8 more words -> RUN entered with correct window; with MSG_SCHEDULE_ABORT_EN, ABORT at T_IDX=10 -> LOAD, no SCHED_DONE.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and sizes for the SHA-256 message schedule block.
package sha256_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int ROUNDS          = 64;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        SEL_SIGMA0 = 1'b0,
        SEL_SIGMA1 = 1'b1
    } sigma_sel_t;

endpackage

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 small sigma: sel chooses sigma0 (7/18/>>3) or sigma1 (17/19/>>10).
module sha256_sigma
    import sha256_pkg::*;
(
    input  sigma_sel_t sel_i,
    input  word_t      x_i,
    output word_t      y_o
);

    word_t s0;
    word_t s1;

    always_comb begin
        s0 = {x_i[6:0],  x_i[31:7]}  ^ {x_i[17:0], x_i[31:18]} ^ {3'b000, x_i[31:3]};
        s1 = {x_i[16:0], x_i[31:17]} ^ {x_i[18:0], x_i[31:19]} ^ {10'd0, x_i[31:10]};
        y_o = (sel_i == SEL_SIGMA1) ? s1 : s0;
    end

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then emits W[0..63] one per ADVANCE.
// Optional ABORT input is present when MSG_SCHEDULE_ABORT_EN is defined.
module msg_schedule
    import sha256_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
`ifdef MSG_SCHEDULE_ABORT_EN
    input  logic        ABORT,
`endif
    input  logic        WORD_VALID,
    input  logic [31:0] WORD_IN,
    input  logic        ADVANCE,
    output logic [31:0] W_OUT,
    output logic [5:0]  T_IDX,
    output logic [4:0]  WORD_CNT,
    output logic        BLOCK_READY,
    output logic        SCHED_DONE
);

    state_t state_q, state_d;
    logic [4:0] word_cnt_q, word_cnt_d;
    logic [5:0] t_idx_q, t_idx_d;
    logic       shift_en;
    logic       load_en;

    logic [WORDS_PER_BLOCK-1:0][31:0] window_q;
    logic [WORDS_PER_BLOCK-1:0][31:0] window_d;

    word_t sig0_y;
    word_t sig1_y;
    word_t new_word;

    sha256_sigma u_sigma0 (
        .sel_i (SEL_SIGMA0),
        .x_i   (window_q[1]),
        .y_o   (sig0_y)
    );

    sha256_sigma u_sigma1 (
        .sel_i (SEL_SIGMA1),
        .x_i   (window_q[14]),
        .y_o   (sig1_y)
    );

    assign new_word = sig1_y + window_q[9] + sig0_y + window_q[0];

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        t_idx_d    = t_idx_q;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (WORD_VALID) begin
                    load_en    = 1'b1;
                    word_cnt_d = word_cnt_q + 5'd1;
                    if (word_cnt_q == 5'(WORDS_PER_BLOCK - 1)) begin
                        state_d = ST_RUN;
                        t_idx_d = 6'd0;
                    end
                end
            end
            ST_RUN: begin
                if (ADVANCE) begin
                    t_idx_d = t_idx_q + 6'd1;
                    // The last round only retires W[63]; no further word is needed.
                    if (t_idx_q == 6'(ROUNDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_LOAD;
                word_cnt_d = 5'd0;
                t_idx_d    = 6'd0;
            end
            default: begin
                state_d    = ST_LOAD;
                word_cnt_d = 5'd0;
                t_idx_d    = 6'd0;
            end
        endcase
`ifdef MSG_SCHEDULE_ABORT_EN
        if (ABORT) begin
            state_d    = ST_LOAD;
            word_cnt_d = 5'd0;
            t_idx_d    = 6'd0;
            shift_en   = 1'b0;
            load_en    = 1'b0;
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_slot
            logic [31:0] shift_src;
            if (gi == WORDS_PER_BLOCK - 1) begin : g_top
                assign shift_src = new_word;
            end else begin : g_mid
                assign shift_src = window_q[gi+1];
            end
            assign window_d[gi] = shift_en ? shift_src :
                                  (load_en && (word_cnt_q[3:0] == 4'(gi))) ? WORD_IN :
                                  window_q[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= ST_LOAD;
            word_cnt_q <= 5'd0;
            t_idx_q    <= 6'd0;
            window_q   <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            t_idx_q    <= t_idx_d;
            window_q   <= window_d;
        end
    end

    assign W_OUT       = window_q[0];
    assign T_IDX       = t_idx_q;
    assign WORD_CNT    = word_cnt_q;
    assign BLOCK_READY = (state_q == ST_RUN);
    assign SCHED_DONE  = (state_q == ST_DONE);

endmodule

// File: tb/tb_msg_schedule.sv
// Scoreboard bench for msg_schedule: reference schedule expanded from the SHA-256 recurrence.
module tb_msg_schedule;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ABORT = 1'b0;
    logic        WORD_VALID = 1'b0;
    logic [31:0] WORD_IN = '0;
    logic        ADVANCE = 1'b0;
    logic [31:0] W_OUT;
    logic [5:0]  T_IDX;
    logic [4:0]  WORD_CNT;
    logic        BLOCK_READY;
    logic        SCHED_DONE;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg [16];
    logic [31:0] sched [64];
    int          exp_t_q [$];
    logic [31:0] exp_w_q [$];

    msg_schedule dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
`ifdef MSG_SCHEDULE_ABORT_EN
        .ABORT       (ABORT),
`endif
        .WORD_VALID  (WORD_VALID),
        .WORD_IN     (WORD_IN),
        .ADVANCE     (ADVANCE),
        .W_OUT       (W_OUT),
        .T_IDX       (T_IDX),
        .WORD_CNT    (WORD_CNT),
        .BLOCK_READY (BLOCK_READY),
        .SCHED_DONE  (SCHED_DONE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic expand();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) sched[t] = msg[t];
            else sched[t] = ssig1(sched[t-2]) + sched[t-7] + ssig0(sched[t-15]) + sched[t-16];
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed word (RUN with ADVANCE) is compared to the scoreboard head.
    always @(negedge CLK) begin
        if (RESET_N && BLOCK_READY && ADVANCE) begin
            if (exp_t_q.size() == 0) begin
                check("unexpected_consume", {58'd0, T_IDX}, 64'hFFFF);
            end else begin
                int          et;
                logic [31:0] ew;
                et = exp_t_q.pop_front();
                ew = exp_w_q.pop_front();
                check("round_t", {58'd0, T_IDX}, 64'(et));
                check("round_w", {32'd0, W_OUT}, {32'd0, ew});
                $display("round t=%0d W_OUT=%08h expected=%08h", T_IDX, W_OUT, ew);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_w"},     {32'd0, W_OUT}, 64'd0);
        check({tag, "_t"},     {58'd0, T_IDX}, 64'd0);
        check({tag, "_cnt"},   {59'd0, WORD_CNT}, 64'd0);
        check({tag, "_ready"}, {63'd0, BLOCK_READY}, 64'd0);
        check({tag, "_done"},  {63'd0, SCHED_DONE}, 64'd0);
    endtask

    task automatic random_msg();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        expand();
    endtask

    task automatic load_block(input int gap_at, input int gap_len);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge CLK); #1;
                    WORD_VALID = 1'b0;
                    ADVANCE    = 1'($urandom % 2);
                end
                @(negedge CLK);
                check("gap_cnt", {59'd0, WORD_CNT}, 64'(i));
                check("gap_ready", {63'd0, BLOCK_READY}, 64'd0);
            end
            @(posedge CLK); #1;
            WORD_VALID = 1'b1;
            WORD_IN    = msg[i];
            ADVANCE    = 1'($urandom % 2);
        end
        @(posedge CLK); #1;
        WORD_VALID = 1'b0;
        ADVANCE    = 1'b0;
        @(negedge CLK);
        check("load_ready", {63'd0, BLOCK_READY}, 64'd1);
        check("load_t",     {58'd0, T_IDX}, 64'd0);
        check("load_cnt",   {59'd0, WORD_CNT}, 64'd16);
        check("load_w0",    {32'd0, W_OUT}, {32'd0, msg[0]});
        $display("block loaded w0=%08h", W_OUT);
    endtask

    task automatic run_rounds(input int n, input bit abc);
        for (int t = 0; t < n; t++) begin
            int          stall;
            logic [31:0] ew;
            stall = int'($urandom_range(0, 2));
            for (int s = 0; s < stall; s++) begin
                @(posedge CLK); #1;
                ADVANCE    = 1'b0;
                WORD_VALID = 1'($urandom % 2);
                WORD_IN    = $urandom;
                @(negedge CLK);
                check("hold_t", {58'd0, T_IDX}, 64'(t));
                check("hold_w", {32'd0, W_OUT}, {32'd0, sched[t]});
            end
            ew = sched[t];
            if (abc && t == 16) ew = 32'h61626380;
            if (abc && t == 17) ew = 32'h000F0000;
            if (abc && t == 63) ew = 32'h12B1EDEB;
            @(posedge CLK); #1;
            WORD_VALID = 1'($urandom % 2);
            WORD_IN    = $urandom;
            ADVANCE    = 1'b1;
            exp_t_q.push_back(t);
            exp_w_q.push_back(ew);
        end
        @(posedge CLK); #1;
        ADVANCE    = 1'b0;
        WORD_VALID = 1'b0;
    endtask

    task automatic done_check();
        @(negedge CLK);
        check("done_pulse", {63'd0, SCHED_DONE}, 64'd1);
        check("done_ready", {63'd0, BLOCK_READY}, 64'd0);
        check("done_t",     {58'd0, T_IDX}, 64'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("done_end",   {63'd0, SCHED_DONE}, 64'd0);
        check("reload_cnt", {59'd0, WORD_CNT}, 64'd0);
        check("reload_rdy", {63'd0, BLOCK_READY}, 64'd0);
        $display("schedule done, back in load");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // ADVANCE while loading must do nothing
        ADVANCE = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        ADVANCE = 1'b0;
        @(negedge CLK);
        check_all_zero("adv_in_load");

        // "abc" padded block
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        expand();
        load_block(-1, 0);
        run_rounds(64, 1'b1);
        done_check();

        // split load with a 20-cycle idle gap
        random_msg();
        load_block(8, 20);
        run_rounds(64, 1'b0);
        done_check();

        // reset in the middle of a run
        random_msg();
        load_block(-1, 0);
        run_rounds(30, 1'b0);
        @(negedge CLK);
        check("pre_reset_t", {58'd0, T_IDX}, 64'd30);
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        check_all_zero("mid_reset");
        $display("mid-run reset applied");

`ifdef MSG_SCHEDULE_ABORT_EN
        random_msg();
        load_block(-1, 0);
        run_rounds(10, 1'b0);
        @(posedge CLK); #1;
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        @(negedge CLK);
        check("abort_ready", {63'd0, BLOCK_READY}, 64'd0);
        check("abort_done",  {63'd0, SCHED_DONE}, 64'd0);
        check("abort_cnt",   {59'd0, WORD_CNT}, 64'd0);
        check("abort_t",     {58'd0, T_IDX}, 64'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("abort_nodone", {63'd0, SCHED_DONE}, 64'd0);
        $display("abort applied at t=10");
`endif

        random_msg();
        load_block(-1, 0);
        run_rounds(64, 1'b0);
        done_check();

        repeat (2) @(posedge CLK);
        check("scoreboard_empty", 64'(exp_t_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
